// File: rtl/muldiv_unit_pkg.sv
// Shared op codes and FSM state encoding for the multiply/divide unit and the ALU decoder.
package muldiv_unit_pkg;

  localparam int unsigned OP_W = 3;

  localparam logic [OP_W-1:0] OP_MULT  = 3'b000;
  localparam logic [OP_W-1:0] OP_MULTU = 3'b001;
  localparam logic [OP_W-1:0] OP_DIV   = 3'b010;
  localparam logic [OP_W-1:0] OP_DIVU  = 3'b011;
  localparam logic [OP_W-1:0] OP_MTHI  = 3'b100;
  localparam logic [OP_W-1:0] OP_MTLO  = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_FIX  = 2'b10
  } state_e;

  // MULT, MULTU, DIV and DIVU all have a zero top bit.
  function automatic logic is_arith(input logic [OP_W-1:0] op);
    return (op[2] == 1'b0);
  endfunction

endpackage

// File: rtl/muldiv_signfix.sv
// Final result shaping: applies result signs to the magnitude result and handles divide by zero.
module muldiv_signfix #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] mag,
  input  logic               is_div,
  input  logic               neg_q,
  input  logic               neg_r,
  input  logic               div_zero,
  input  logic [WIDTH-1:0]   raw_a,
  output logic [WIDTH-1:0]   res_hi_c,
  output logic [WIDTH-1:0]   res_lo_c
);

  localparam int unsigned AW = 2 * WIDTH;

  logic [AW-1:0]    prod;
  logic [WIDTH-1:0] q_mag;
  logic [WIDTH-1:0] r_mag;

  // Multiply negates the whole product; divide negates quotient and remainder independently.
  always_comb begin
    prod     = neg_q ? -mag : mag;
    q_mag    = mag[WIDTH-1:0];
    r_mag    = mag[AW-1:WIDTH];
    res_hi_c = prod[AW-1:WIDTH];
    res_lo_c = prod[WIDTH-1:0];
    if (is_div) begin
      if (div_zero) begin
        res_hi_c = raw_a;
        res_lo_c = '1;
      end else begin
        res_hi_c = neg_r ? -r_mag : r_mag;
        res_lo_c = neg_q ? -q_mag : q_mag;
      end
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide engine with architectural HI/LO registers; one result bit per cycle.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam int unsigned AW = 2 * WIDTH;

  state_e           state;
  state_e           state_nxt;
  logic [CW-1:0]    cnt;
  logic [AW-1:0]    acc;
  logic [WIDTH-1:0] opnd_b;
  logic [WIDTH-1:0] raw_a;
  logic             is_div;
  logic             neg_q;
  logic             neg_r;
  logic             div_zero;

  logic             busy_nxt;
  logic             done_nxt;

  logic             accept;
  logic             go;
  logic             is_signed;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;

  logic [WIDTH:0]   msum;
  logic [AW-1:0]    mul_step;
  logic [WIDTH:0]   rem_sh;
  logic             borrow;
  logic [WIDTH-1:0] rem_diff;
  logic [AW-1:0]    div_step;

  logic [WIDTH-1:0] res_hi_c;
  logic [WIDTH-1:0] res_lo_c;

  // Request decode and operand magnitudes; unsigned ops pass operands through untouched.
  always_comb begin
    accept    = (state == ST_IDLE) && start;
    go        = accept && is_arith(op);
    is_signed = ~op[0];
    a_neg     = is_signed && a[WIDTH-1];
    b_neg     = is_signed && b[WIDTH-1];
    a_mag     = a_neg ? -a : a;
    b_mag     = b_neg ? -b : b;
  end

  // One iteration of shift-add multiply and restoring divide.
  always_comb begin
    msum     = {1'b0, acc[AW-1:WIDTH]} + {1'b0, opnd_b & {WIDTH{acc[0]}}};
    mul_step = {msum, acc[WIDTH-1:1]};
    rem_sh   = acc[AW-1:WIDTH-1];
    borrow   = (rem_sh < {1'b0, opnd_b});
    rem_diff = rem_sh[WIDTH-1:0] - opnd_b;
    div_step = {(borrow ? rem_sh[WIDTH-1:0] : rem_diff), acc[WIDTH-2:0], ~borrow};
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (go) state_nxt = ST_RUN;
      ST_RUN:  if (cnt == '0) state_nxt = ST_FIX;
      ST_FIX:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Output decode; busy covers RUN and FIX, done follows the FIX edge.
  always_comb begin
    busy_nxt = (state_nxt != ST_IDLE);
    done_nxt = (state == ST_FIX);
  end

  muldiv_signfix #(.WIDTH(WIDTH)) u_signfix (
    .mag      (acc),
    .is_div   (is_div),
    .neg_q    (neg_q),
    .neg_r    (neg_r),
    .div_zero (div_zero),
    .raw_a    (raw_a),
    .res_hi_c (res_hi_c),
    .res_lo_c (res_lo_c)
  );

  // Datapath, counter and HI/LO registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      busy     <= 1'b0;
      done     <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      cnt      <= '0;
      acc      <= '0;
      opnd_b   <= '0;
      raw_a    <= '0;
      is_div   <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      busy <= busy_nxt;
      done <= done_nxt;
      case (state)
        ST_IDLE: begin
          if (go) begin
            acc      <= {{WIDTH{1'b0}}, a_mag};
            opnd_b   <= b_mag;
            raw_a    <= a;
            is_div   <= op[1];
            neg_q    <= a_neg ^ b_neg;
            neg_r    <= a_neg;
            div_zero <= (b == '0);
            cnt      <= CW'(WIDTH - 1);
          end
          if (accept && (op == OP_MTHI)) hi <= a;
          if (accept && (op == OP_MTLO)) lo <= a;
        end
        ST_RUN: begin
          acc <= is_div ? div_step : mul_step;
          cnt <= cnt - CW'(1);
        end
        ST_FIX: begin
          hi <= res_hi_c;
          lo <= res_lo_c;
        end
        default: ;
      endcase
    end
  end

endmodule
